// File: rtl/mcs6530_pkg.sv
// Shared types and constants for the mcs6530 bus master.
// Bus state enum, address width and bus idle values.
package mcs6530_pkg;

  localparam int ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } bm_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic              rs_n;
    logic              we_n;
    logic [7:0]        di;
  } bus_drv_t;

  localparam logic [ADDR_W-1:0] BUS_IDLE_A    = '0;
  localparam logic              BUS_IDLE_RS_N = 1'b1;
  localparam logic              BUS_IDLE_WE_N = 1'b1;
  localparam logic [7:0]        BUS_IDLE_DI   = 8'h00;

  localparam bus_drv_t BUS_IDLE = '{
    a:    BUS_IDLE_A,
    rs_n: BUS_IDLE_RS_N,
    we_n: BUS_IDLE_WE_N,
    di:   BUS_IDLE_DI
  };

  function automatic bus_drv_t bus_drive(
    input logic [ADDR_W-1:0] a,
    input logic              rs_n,
    input logic              we,
    input logic [7:0]        di
  );
    bus_drv_t d;
    d.a    = a;
    d.rs_n = rs_n;
    d.we_n = ~we;
    d.di   = di;
    return d;
  endfunction

endpackage

// File: rtl/mcs6530_bus_master_if.sv
// Command, response and 6502-style bus signals of the bus master.
// master: the bus master itself; slave: command source + bus slave.
interface mcs6530_bus_master_if
  import mcs6530_pkg::*;
#(
  parameter int MAX_LEN_W = 4
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_we;
  logic                 cmd_rs_n;
  logic [ADDR_W-1:0]    cmd_addr;
  logic [MAX_LEN_W-1:0] cmd_len;
  logic [7:0]           cmd_wdata;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [7:0]           rsp_data;
  logic                 rsp_last;

  logic [ADDR_W-1:0]    A;
  logic                 RS_n;
  logic                 we_n;
  logic [7:0]           DI;
  logic [7:0]           DO;

  logic                 busy;

  modport master (
    input  cmd_valid, cmd_we, cmd_rs_n,
    input  cmd_addr, cmd_len, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_last,
    input  rsp_ready,
    output A, RS_n, we_n, DI,
    input  DO,
    output busy
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_rs_n,
    output cmd_addr, cmd_len, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_last,
    output rsp_ready,
    input  A, RS_n, we_n, DI,
    output DO,
    input  busy
  );

endinterface

// File: rtl/mcs6530_bus_master.sv
// 6502-style bus initiator: single/burst reads and fill-writes.
// Ports: phi2, rst_n (async, active-low), bus (master modport).
module mcs6530_bus_master
  import mcs6530_pkg::*;
#(
  parameter int MAX_LEN_W = 4
) (
  input  logic phi2,
  input  logic rst_n,
  mcs6530_bus_master_if.master bus
);

  bm_state_t            state;
  bus_drv_t             drv;
  logic [ADDR_W-1:0]    addr;
  logic [ADDR_W-1:0]    addr_n;
  logic [MAX_LEN_W-1:0] cnt;
  logic                 we;
  logic                 rs_n;
  logic [7:0]           wdata;
  logic                 cmd_ready;
  logic                 rsp_valid;
  logic [7:0]           rsp_data;
  logic                 rsp_last;
  logic                 busy;
  logic                 last_beat;

  // Wraps modulo 1024 by width.
  assign addr_n    = addr + ADDR_W'(1);
  assign last_beat = (cnt == '0);

  assign bus.A         = drv.a;
  assign bus.RS_n      = drv.rs_n;
  assign bus.we_n      = drv.we_n;
  assign bus.DI        = drv.di;
  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_last  = rsp_last;
  assign bus.busy      = busy;

  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drv       <= BUS_IDLE;
      addr      <= '0;
      cnt       <= '0;
      we        <= 1'b0;
      rs_n      <= 1'b1;
      wdata     <= 8'h00;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (bus.cmd_valid && cmd_ready) begin
            addr      <= bus.cmd_addr;
            cnt       <= bus.cmd_len;
            we        <= bus.cmd_we;
            rs_n      <= bus.cmd_rs_n;
            wdata     <= bus.cmd_wdata;
            drv       <= bus_drive(bus.cmd_addr,
                                   bus.cmd_rs_n,
                                   bus.cmd_we,
                                   bus.cmd_wdata);
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          state <= DATA;
        end
        DATA: begin
          if (!we) begin
            // Slave read data is valid on this edge.
            rsp_data  <= bus.DO;
            rsp_last  <= last_beat;
            rsp_valid <= 1'b1;
            drv       <= BUS_IDLE;
            state     <= RESP;
          end else if (!last_beat) begin
            cnt   <= cnt - MAX_LEN_W'(1);
            addr  <= addr_n;
            drv   <= bus_drive(addr_n, rs_n,
                               we, wdata);
            state <= ADDR;
          end else begin
            // A fill-write reports once, at the end.
            rsp_data  <= 8'h00;
            rsp_last  <= 1'b1;
            rsp_valid <= 1'b1;
            drv       <= BUS_IDLE;
            state     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            if (!last_beat) begin
              cnt   <= cnt - MAX_LEN_W'(1);
              addr  <= addr_n;
              drv   <= bus_drive(addr_n, rs_n,
                                 we, wdata);
              state <= ADDR;
            end else begin
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          drv   <= BUS_IDLE;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
